pe_inject_arbiter: RTL and testbench
====================================

PE_INJECT_ARBITER -- requirements
Module: pe_inject_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one NoC injection port.
REQ-002 The block SHALL have parameter DW, default 20, giving the flit width; bits [DW-1:DW-2] are flit type: 00 single, 01 head, 10 body, 11 tail.
REQ-003 The block SHALL have parameter CREDITS, default 7, giving the downstream buffer depth, with a range of 1..7.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, NREQ bits: per-requester flit-pending flag.
REQ-007 The block SHALL have port flit_in, input, NREQ*DW bits: requester i's flit occupies bits [i*DW +: DW].
REQ-008 The block SHALL have port gnt, output, NREQ bits: one-hot combinational grant; the requester pops its flit when gnt[i] is high.
REQ-009 The block SHALL have port ci, input, 1 bit: credit return, one credit per high cycle.
REQ-010 The block SHALL have port dataout, output, DW bits: registered injected flit.
REQ-011 The block SHALL have port out_valid, output, 1 bit: dataout is valid for this cycle.
REQ-012 The block SHALL have port credit, output, 3 bits: current credit count.
REQ-013 The block SHALL have port cr_err, output, 1 bit: sticky flag raised when a credit overflow occurs.

Function
REQ-014 The send condition SHALL be: gnt is nonzero; gnt SHALL be asserted only when credit > 0 and the selected req is high.
REQ-015 Arbitration SHALL be round-robin: search starts at index (last_gnt+1) mod NREQ, and the first high req wins.
REQ-016 last_gnt SHALL update only on a send.
REQ-017 Latency SHALL be one cycle: on the edge after a send, dataout <= granted flit and out_valid <= 1.
REQ-018 Without a send, out_valid SHALL be 0 on the next cycle and dataout SHALL hold its previous value.
REQ-019 The credit update SHALL be:
  - send and no ci: credit-1
  - ci and no send: credit+1
  - both: unchanged
  - neither: unchanged
REQ-020 When credit == 0, gnt SHALL be 0 regardless of req; a ci in that cycle SHALL allow a grant only from the next cycle on.
REQ-021 When ci is high at credit == CREDITS with no send, credit SHALL stay at CREDITS and cr_err SHALL be set.
REQ-022 cr_err SHALL clear only on reset.
REQ-023 The state machine SHALL have states IDLE and LOCKED, and SHALL be active only when PKT_LOCK_EN is defined.
REQ-024 In IDLE, a send of a head flit SHALL cause a transition to LOCKED with owner = granted index.
REQ-025 In IDLE, a send of a single, body or tail flit SHALL leave the state in IDLE.
REQ-026 In LOCKED, only owner SHALL be eligible for a grant; other requests SHALL wait even if credits are available.
REQ-027 In LOCKED, a send of a tail flit from owner SHALL cause a transition to IDLE, with last_gnt = owner.
REQ-028 In LOCKED, a body or head flit from owner SHALL keep the state in LOCKED.
REQ-029 gnt SHALL never have more than one bit set.

Reset
REQ-030 While rst is low, the outputs SHALL be: credit = CREDITS, out_valid = 0, dataout = 0, cr_err = 0, gnt = 0.
REQ-031 While rst is low, internal state SHALL be: state = IDLE, last_gnt = NREQ-1, so that requester 0 has first priority.
REQ-032 Reset asserted mid-packet SHALL abandon the lock immediately.
REQ-033 Reset asserted mid-packet SHALL discard the in-flight output flit, and credits SHALL be restored to CREDITS without requiring ci.
REQ-034 The first send after reset release SHALL be possible on the first rising edge at which rst is high.

Configuration
REQ-035 With macro PE_INJECT_PKT_LOCK_EN defined, the block SHALL implement the wormhole lock of REQ-023..REQ-028.
REQ-036 With PE_INJECT_PKT_LOCK_EN undefined, the block SHALL arbitrate every flit independently, ignore the flit type bits, and keep state tied to IDLE.

Verification
REQ-037 The bench SHALL cover: req=4'b1111 continuously, ci tied high -> gnt sequence 0001, 0010, 0100, 1000, 0001; credit stays 7; out_valid high every cycle after the first.
REQ-038 The bench SHALL cover: req=4'b0001, ci=0 for 9 cycles -> exactly 7 grants; credit reaches 0; gnt=0 afterwards; one ci pulse -> exactly one further grant on the following cycle.
REQ-039 The bench SHALL cover, with lock enabled: req0 sends head, body, tail while req1 is held high -> gnt[1] stays low until the cycle after req0's tail is sent, then gnt=0010.
REQ-040 The bench SHALL cover: ci high at credit 7 with req=0 -> credit stays 7 and cr_err=1 from the next cycle until reset.
REQ-041 The bench SHALL cover: rst pulsed low while LOCKED with credit=3 -> immediately credit=7, out_valid=0, gnt=0; after release, req=4'b0110 -> first grant is 0010.
REQ-042 The bench SHALL cover, with lock disabled: the REQ-039 stimulus -> grants alternate 0001, 0010 per cycle.

Source files
------------

// File: rtl/pe_inject_arbiter.sv
// Round-robin, credit-gated arbiter that merges NREQ requester flit streams onto one NoC injection port.
// Define PE_INJECT_PKT_LOCK_EN to hold the grant on one requester from a head flit until its tail flit.
module pe_inject_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 20,
    parameter int CREDITS = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] flit_in,
    output logic [NREQ-1:0]    gnt,
    input  logic               ci,
    output logic [DW-1:0]      dataout,
    output logic               out_valid,
    output logic [2:0]         credit,
    output logic               cr_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0] CREDIT_MAX = 3'(CREDITS);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_gnt_q, last_gnt_d;
    logic [2:0]      credit_q, credit_d;
    logic [DW-1:0]   dataout_q, dataout_d;
    logic            out_valid_q, out_valid_d;
    logic            cr_err_q, cr_err_d;

    logic            gnt_any;
    logic            send;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   cand;
    logic [DW-1:0]   sel_flit;
    logic [1:0]      sel_type;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (credit_q != 3'd0) begin
            if (state_q == LOCKED) begin
                if (req[owner_q]) begin
                    gnt_any = 1'b1;
                    gnt_idx = owner_q;
                end
            end else begin
                for (int off = 1; off <= NREQ; off++) begin
                    cand = IW'((int'(last_gnt_q) + off) % NREQ);
                    if (!gnt_any && req[cand]) begin
                        gnt_any = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
        end
    end

    // The grant is combinational, so it is also masked while reset is held.
    assign send = gnt_any && rst;

    always_comb begin
        gnt      = '0;
        sel_flit = '0;
        if (send) begin
            gnt[gnt_idx] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                sel_flit = flit_in[i*DW +: DW];
            end
        end
    end

    assign sel_type = sel_flit[DW-1:DW-2];

    always_comb begin
        credit_d    = credit_q;
        cr_err_d    = cr_err_q;
        out_valid_d = send;
        dataout_d   = send ? sel_flit : dataout_q;
        last_gnt_d  = send ? gnt_idx : last_gnt_q;

        if (send && !ci) begin
            credit_d = credit_q - 3'd1;
        end else if (ci && !send) begin
            // A credit arriving at a full counter is a protocol error, not a wrap.
            if (credit_q == CREDIT_MAX) begin
                cr_err_d = 1'b1;
            end else begin
                credit_d = credit_q + 3'd1;
            end
        end
    end

`ifdef PE_INJECT_PKT_LOCK_EN
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (send && sel_type == 2'b01) begin
                    state_d = LOCKED;
                    owner_d = gnt_idx;
                end
            end
            LOCKED: begin
                if (send && sel_type == 2'b11) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`else
    always_comb begin
        state_d = IDLE;
        owner_d = '0;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_gnt_q  <= IW'(NREQ - 1);
            credit_q    <= CREDIT_MAX;
            dataout_q   <= '0;
            out_valid_q <= 1'b0;
            cr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            credit_q    <= credit_d;
            dataout_q   <= dataout_d;
            out_valid_q <= out_valid_d;
            cr_err_q    <= cr_err_d;
        end
    end

    assign dataout   = dataout_q;
    assign out_valid = out_valid_q;
    assign credit    = credit_q;
    assign cr_err    = cr_err_q;

    logic unused_sel_type;
    assign unused_sel_type = ^sel_type;

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// Directed scoreboard bench for pe_inject_arbiter; expectations follow PE_INJECT_PKT_LOCK_EN when it is defined.
module tb_pe_inject_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 20;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] flit_in = '0;
    logic               ci = 1'b0;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      dataout;
    logic               out_valid;
    logic [2:0]         credit;
    logic               cr_err;

    int errors = 0;
    int checks = 0;
    int step   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_out = '0;

    pe_inject_arbiter #(.NREQ(NREQ), .DW(DW), .CREDITS(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .flit_in  (flit_in),
        .gnt      (gnt),
        .ci       (ci),
        .dataout  (dataout),
        .out_valid(out_valid),
        .credit   (credit),
        .cr_err   (cr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset is asserted mid-cycle with req left as-is, so the grant masking is visible too.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        ci  = 1'b0;
        #1;
        check({tag, " rst credit"},    32'(credit),    32'd7);
        check({tag, " rst out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " rst gnt"},       32'(gnt),       32'd0);
        check({tag, " rst dataout"},   32'(dataout),   32'd0);
        check({tag, " rst cr_err"},    32'(cr_err),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = '0;
        exp_q.delete();
        last_out = '0;
    endtask

    task automatic cycle(input string tag, input logic [3:0] r, input logic c,
                         input logic [1:0] t0, input logic [1:0] t1,
                         input logic [3:0] eg, input logic [2:0] ecred, input logic ecr);
        logic [DW-1:0] lane [NREQ];
        logic [DW-1:0] e;
        @(negedge clk);
        step++;
        for (int i = 0; i < NREQ; i++) begin
            lane[i] = {(i == 0) ? t0 : (i == 1) ? t1 : 2'b00, 2'(i), 16'(step)};
        end
        flit_in = {lane[3], lane[2], lane[1], lane[0]};
        req = r;
        ci  = c;
        #1;
        check({tag, " gnt"}, 32'(gnt), 32'(eg));
        for (int i = 0; i < NREQ; i++) begin
            if (eg[i]) exp_q.push_back(lane[i]);
        end
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'(eg != 4'd0));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            last_out = e;
            check({tag, " dataout"}, 32'(dataout), 32'(e));
        end else begin
            check({tag, " dataout hold"}, 32'(dataout), 32'(last_out));
        end
        check({tag, " credit"}, 32'(credit), 32'(ecred));
        check({tag, " cr_err"}, 32'(cr_err), 32'(ecr));
    endtask

    initial begin
        do_reset("por");

        // Full contention with credits returned every cycle.
        cycle("rr0", 4'b1111, 1'b1, 2'b00, 2'b00, 4'b0001, 3'd7, 1'b0);
        cycle("rr1", 4'b1111, 1'b1, 2'b00, 2'b00, 4'b0010, 3'd7, 1'b0);
        cycle("rr2", 4'b1111, 1'b1, 2'b00, 2'b00, 4'b0100, 3'd7, 1'b0);
        cycle("rr3", 4'b1111, 1'b1, 2'b00, 2'b00, 4'b1000, 3'd7, 1'b0);
        cycle("rr4", 4'b1111, 1'b1, 2'b00, 2'b00, 4'b0001, 3'd7, 1'b0);

        // Credit exhaustion, then a single returned credit.
        do_reset("cr");
        for (int k = 0; k < 7; k++) begin
            cycle("drain", 4'b0001, 1'b0, 2'b00, 2'b00, 4'b0001, 3'(6 - k), 1'b0);
        end
        cycle("empty8", 4'b0001, 1'b0, 2'b00, 2'b00, 4'b0000, 3'd0, 1'b0);
        cycle("empty9", 4'b0001, 1'b0, 2'b00, 2'b00, 4'b0000, 3'd0, 1'b0);
        cycle("ci_pulse", 4'b0001, 1'b1, 2'b00, 2'b00, 4'b0000, 3'd1, 1'b0);
        cycle("one_more", 4'b0001, 1'b0, 2'b00, 2'b00, 4'b0001, 3'd0, 1'b0);
        cycle("empty_again", 4'b0001, 1'b0, 2'b00, 2'b00, 4'b0000, 3'd0, 1'b0);

        // Packet from requester 0 while requester 1 keeps asking.
        do_reset("pkt");
`ifdef PE_INJECT_PKT_LOCK_EN
        cycle("lk_head", 4'b0011, 1'b1, 2'b01, 2'b00, 4'b0001, 3'd7, 1'b0);
        cycle("lk_body", 4'b0011, 1'b1, 2'b10, 2'b00, 4'b0001, 3'd7, 1'b0);
        cycle("lk_tail", 4'b0011, 1'b1, 2'b11, 2'b00, 4'b0001, 3'd7, 1'b0);
        cycle("lk_next", 4'b0010, 1'b1, 2'b00, 2'b00, 4'b0010, 3'd7, 1'b0);
`else
        cycle("nl_head", 4'b0011, 1'b1, 2'b01, 2'b00, 4'b0001, 3'd7, 1'b0);
        cycle("nl_r1a",  4'b0011, 1'b1, 2'b10, 2'b00, 4'b0010, 3'd7, 1'b0);
        cycle("nl_body", 4'b0011, 1'b1, 2'b10, 2'b00, 4'b0001, 3'd7, 1'b0);
        cycle("nl_r1b",  4'b0011, 1'b1, 2'b11, 2'b00, 4'b0010, 3'd7, 1'b0);
        cycle("nl_tail", 4'b0011, 1'b1, 2'b11, 2'b00, 4'b0001, 3'd7, 1'b0);
        cycle("nl_r1c",  4'b0010, 1'b1, 2'b00, 2'b00, 4'b0010, 3'd7, 1'b0);
`endif

        // Credit overflow is sticky until reset.
        do_reset("ovf");
        cycle("ovf_ci",   4'b0000, 1'b1, 2'b00, 2'b00, 4'b0000, 3'd7, 1'b1);
        cycle("ovf_hold", 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, 3'd7, 1'b1);
        cycle("ovf_send", 4'b0001, 1'b0, 2'b00, 2'b00, 4'b0001, 3'd6, 1'b1);
        do_reset("ovf_clr");

        // Reset in the middle of a packet with three credits left.
        cycle("mid_head", 4'b0001, 1'b0, 2'b01, 2'b00, 4'b0001, 3'd6, 1'b0);
        cycle("mid_b0",   4'b0001, 1'b0, 2'b10, 2'b00, 4'b0001, 3'd5, 1'b0);
        cycle("mid_b1",   4'b0001, 1'b0, 2'b10, 2'b00, 4'b0001, 3'd4, 1'b0);
        cycle("mid_b2",   4'b0001, 1'b0, 2'b10, 2'b00, 4'b0001, 3'd3, 1'b0);
        do_reset("mid");
        cycle("post_rst0", 4'b0110, 1'b0, 2'b00, 2'b00, 4'b0010, 3'd6, 1'b0);
        cycle("post_rst1", 4'b0110, 1'b0, 2'b00, 2'b00, 4'b0100, 3'd5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
